// File: rtl/gps_zda_gen.sv
// NMEA $GPZDA sentence generator streaming ASCII bytes over AXI-stream to a UART.
// Define NMEA_CHECKSUM_EN for the 38-byte frame with "*CS"; undefined gives the 35-byte frame.
module gps_zda_gen #(
    parameter logic [15:0] TALKER  = 16'h4750,
    parameter logic [7:0]  ZONE_HH = 8'h00,
    parameter logic [7:0]  ZONE_MM = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] time_bcd,
    input  logic [31:0] date_bcd,
    output logic [7:0]  axis_tdata,
    output logic        axis_tvalid,
    input  logic        axis_tready,
    output logic        busy,
    output logic        done,
    output logic        bad_digit
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

`ifdef NMEA_CHECKSUM_EN
    localparam logic [5:0] LAST_IDX = 6'd37;
`else
    localparam logic [5:0] LAST_IDX = 6'd34;
`endif

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] time_q, time_d;
    logic [31:0] date_q, date_d;
    logic        bad_q, bad_d;
    logic [7:0]  byte_c;
    logic        fire;
    logic        last;
    logic        capture;
    logic        bad_in;
`ifdef NMEA_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    function automatic logic [7:0] dig(input logic [3:0] n);
        return (n > 4'd9) ? 8'h3F : {4'h3, n};
    endfunction

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n > 4'd9) ? (8'h37 + {4'h0, n}) : {4'h3, n};
    endfunction

    assign fire    = axis_tvalid && axis_tready;
    assign last    = (idx_q == LAST_IDX);
    assign capture = (state_q == S_IDLE) && start;

    always_comb begin
        bad_in = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (time_bcd[4*i +: 4] > 4'd9 || date_bcd[4*i +: 4] > 4'd9) begin
                bad_in = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            time_q  <= '0;
            date_q  <= '0;
            bad_q   <= 1'b0;
`ifdef NMEA_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            time_q  <= time_d;
            date_q  <= date_d;
            bad_q   <= bad_d;
`ifdef NMEA_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SEND;
            S_SEND:  if (fire && last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        time_d = time_q;
        date_d = date_q;
        bad_d  = bad_q;
`ifdef NMEA_CHECKSUM_EN
        csum_d = csum_q;
`endif
        if (capture) begin
            idx_d  = '0;
            time_d = time_bcd;
            date_d = date_bcd;
            bad_d  = bad_in;
`ifdef NMEA_CHECKSUM_EN
            csum_d = '0;
`endif
        end else if (fire) begin
            idx_d = last ? '0 : idx_q + 6'd1;
`ifdef NMEA_CHECKSUM_EN
            // Bytes 1..32 are everything between '$' and '*'.
            if (idx_q != 6'd0 && idx_q < 6'd33) begin
                csum_d = csum_q ^ byte_c;
            end
`endif
        end
    end

    always_comb begin
        byte_c = 8'h00;
        case (idx_q)
            6'd0:    byte_c = 8'h24;
            6'd1:    byte_c = TALKER[15:8];
            6'd2:    byte_c = TALKER[7:0];
            6'd3:    byte_c = 8'h5A;
            6'd4:    byte_c = 8'h44;
            6'd5:    byte_c = 8'h41;
            6'd6:    byte_c = 8'h2C;
            6'd7:    byte_c = dig(time_q[31:28]);
            6'd8:    byte_c = dig(time_q[27:24]);
            6'd9:    byte_c = dig(time_q[23:20]);
            6'd10:   byte_c = dig(time_q[19:16]);
            6'd11:   byte_c = dig(time_q[15:12]);
            6'd12:   byte_c = dig(time_q[11:8]);
            6'd13:   byte_c = 8'h2E;
            6'd14:   byte_c = dig(time_q[7:4]);
            6'd15:   byte_c = dig(time_q[3:0]);
            6'd16:   byte_c = 8'h2C;
            6'd17:   byte_c = dig(date_q[31:28]);
            6'd18:   byte_c = dig(date_q[27:24]);
            6'd19:   byte_c = 8'h2C;
            6'd20:   byte_c = dig(date_q[23:20]);
            6'd21:   byte_c = dig(date_q[19:16]);
            6'd22:   byte_c = 8'h2C;
            6'd23:   byte_c = dig(date_q[15:12]);
            6'd24:   byte_c = dig(date_q[11:8]);
            6'd25:   byte_c = dig(date_q[7:4]);
            6'd26:   byte_c = dig(date_q[3:0]);
            6'd27:   byte_c = 8'h2C;
            6'd28:   byte_c = dig(ZONE_HH[7:4]);
            6'd29:   byte_c = dig(ZONE_HH[3:0]);
            6'd30:   byte_c = 8'h2C;
            6'd31:   byte_c = dig(ZONE_MM[7:4]);
            6'd32:   byte_c = dig(ZONE_MM[3:0]);
`ifdef NMEA_CHECKSUM_EN
            6'd33:   byte_c = 8'h2A;
            6'd34:   byte_c = hexc(csum_q[7:4]);
            6'd35:   byte_c = hexc(csum_q[3:0]);
            6'd36:   byte_c = 8'h0D;
            6'd37:   byte_c = 8'h0A;
`else
            6'd33:   byte_c = 8'h0D;
            6'd34:   byte_c = 8'h0A;
`endif
            default: byte_c = 8'h00;
        endcase
    end

    always_comb begin
        axis_tvalid = (state_q == S_SEND);
        busy        = (state_q == S_SEND);
        done        = (state_q == S_DONE);
        axis_tdata  = (state_q == S_SEND) ? byte_c : '0;
        bad_digit   = bad_q;
    end

endmodule

// File: tb/tb_gps_zda_gen.sv
// Directed bench for gps_zda_gen: frame contents, backpressure, bad digits, ignored starts, reset mid-frame.
module tb_gps_zda_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] time_bcd;
    logic [31:0] date_bcd;
    logic [7:0]  axis_tdata;
    logic        axis_tvalid;
    logic        axis_tready;
    logic        busy;
    logic        done;
    logic        bad_digit;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rx [0:63];
    int         rx_n;
    int         busy_cyc;
    int         done_cnt;
    string      exp_basic;
    string      exp_bad;

    always #5 clk = ~clk;

    gps_zda_gen dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .time_bcd    (time_bcd),
        .date_bcd    (date_bcd),
        .axis_tdata  (axis_tdata),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .busy        (busy),
        .done        (done),
        .bad_digit   (bad_digit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; leaves the bench at the first SEND negedge.
    task automatic start_frame(input logic [31:0] t, input logic [31:0] d);
        time_bcd = t;
        date_bcd = d;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        time_bcd = 32'h99999999;
        date_bcd = 32'h99999999;
        check("lat_tvalid", {31'b0, axis_tvalid}, 32'd1);
        check("lat_busy", {31'b0, busy}, 32'd1);
        check("first_byte", {24'b0, axis_tdata}, 32'h24);
    endtask

    // kind 0: plain, 1: start pulses at byte 10 and in DONE, 2: reset at byte 20
    task automatic run_frame(input int bp, input int kind);
        int   post;
        logic stall;
        logic [7:0] held;
        logic ev;
        logic finished;
        rx_n = 0; busy_cyc = 0; done_cnt = 0;
        post = -1; stall = 1'b0; held = 8'h00; ev = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            start = 1'b0;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                post = 0;
                if (kind == 1) begin
                    start    = 1'b1;
                    time_bcd = 32'h01020304;
                end
            end
            if (stall && axis_tvalid) check("tdata_hold", {24'b0, axis_tdata}, {24'b0, held});
            if (kind == 1 && !ev && axis_tvalid && rx_n == 10) begin
                start    = 1'b1;
                time_bcd = 32'h11223344;
                date_bcd = 32'h01010101;
                ev       = 1'b1;
            end
            if (kind == 2 && axis_tvalid && rx_n == 20) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_tvalid", {31'b0, axis_tvalid}, 32'd0);
                check("rst_busy", {31'b0, busy}, 32'd0);
                return;
            end
            axis_tready = (bp == 0) ? 1'b1 : ($urandom_range(0, 99) >= bp);
            if (axis_tvalid && axis_tready && rx_n < 64) begin
                rx[rx_n] = axis_tdata;
                rx_n++;
            end
            stall = axis_tvalid && !axis_tready;
            held  = axis_tdata;
            if (post >= 0) begin
                if (post == 8) finished = 1'b1;
                post++;
            end
            if (!finished) @(negedge clk);
        end
        check("frame_done", {31'b0, (post >= 0)}, 32'd1);
    endtask

    task automatic compare_frame(input string tag, input string exp);
        check({tag, "_len"}, rx_n, exp.len());
        for (int i = 0; i < exp.len() && i < 64; i++) begin
            check($sformatf("%s_b%0d", tag, i), {24'b0, rx[i]}, {24'b0, exp[i]});
        end
    endtask

    initial begin
`ifdef NMEA_CHECKSUM_EN
        exp_basic = "$GPZDA,210935.00,13,11,2020,00,00*68\015\012";
        exp_bad   = "$GPZDA,2?0935.00,13,11,2020,00,00*66\015\012";
`else
        exp_basic = "$GPZDA,210935.00,13,11,2020,00,00\015\012";
        exp_bad   = "$GPZDA,2?0935.00,13,11,2020,00,00\015\012";
`endif
        rst = 1'b1; start = 1'b0; axis_tready = 1'b0;
        time_bcd = '0; date_bcd = '0;
        repeat (3) @(negedge clk);
        check("rst_tvalid0", {31'b0, axis_tvalid}, 32'd0);
        check("rst_tdata0", {24'b0, axis_tdata}, 32'h00);
        check("rst_busy0", {31'b0, busy}, 32'd0);
        check("rst_done0", {31'b0, done}, 32'd0);
        check("rst_bad0", {31'b0, bad_digit}, 32'd0);
        rst = 1'b0;
        axis_tready = 1'b1;
        @(negedge clk);
        check("idle_tvalid", {31'b0, axis_tvalid}, 32'd0);

        start_frame(32'h21093500, 32'h13112020);
        check("basic_bad", {31'b0, bad_digit}, 32'd0);
        run_frame(0, 0);
        compare_frame("basic", exp_basic);
        check("basic_busy_cyc", busy_cyc, exp_basic.len());
        check("basic_done_cnt", done_cnt, 32'd1);
        check("idle_tdata", {24'b0, axis_tdata}, 32'h00);

        start_frame(32'h21093500, 32'h13112020);
        run_frame(30, 0);
        compare_frame("bp", exp_basic);
        check("bp_done_cnt", done_cnt, 32'd1);

        start_frame(32'h2A093500, 32'h13112020);
        check("bad_flag", {31'b0, bad_digit}, 32'd1);
        run_frame(0, 0);
        compare_frame("bad", exp_bad);
        check("bad_held", {31'b0, bad_digit}, 32'd1);

        start_frame(32'h21093500, 32'h13112020);
        check("bad_cleared", {31'b0, bad_digit}, 32'd0);
        run_frame(0, 1);
        compare_frame("busy_start", exp_basic);
        check("busy_start_done", done_cnt, 32'd1);
        check("busy_start_idle", {31'b0, axis_tvalid}, 32'd0);

        start_frame(32'h21093500, 32'h13112020);
        run_frame(0, 2);
        check("after_rst_rx", rx_n, 32'd20);
        @(negedge clk);
        check("after_rst_idle", {31'b0, axis_tvalid}, 32'd0);
        start_frame(32'h21093500, 32'h13112020);
        run_frame(0, 0);
        compare_frame("post_rst", exp_basic);
        check("post_rst_done", done_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
        $fatal(1);
    end

endmodule
